// File: rtl/imm_extend_seq.sv
// Registered immediate extender with a two-instruction prefix merge.
// One pipeline stage between decode and execute, with stall and flush.
module imm_extend_seq #(
   parameter int unsigned INSTR_W  = 28,
   parameter int unsigned OUT_W    = 32,
   parameter int unsigned PREFIX_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [INSTR_W-1:0] Instr,
   input  logic [2:0]         ImmSrc,
   input  logic               stall,
   input  logic               flush,
   output logic               out_valid,
   output logic [OUT_W-1:0]   ExtImm,
   output logic               prefix_pending
);

   localparam int unsigned LOW_W  = OUT_W - PREFIX_W;
   localparam int unsigned BASE_W = (INSTR_W > 19) ? INSTR_W : 19;
   localparam int unsigned WIDE_W = (BASE_W > PREFIX_W) ? BASE_W : PREFIX_W;

   typedef enum logic {IDLE, PREFIX} state_t;

   state_t              state, state_nxt;
   logic [PREFIX_W-1:0] prefix_reg, prefix_nxt;
   logic [OUT_W-1:0]    ext_nxt;
   logic                out_valid_nxt;
   logic [WIDE_W-1:0]   instr_w;
   logic [OUT_W-1:0]    field_c;
   logic [OUT_W-1:0]    merged_c;
   logic                unused_instr;

   // Widen so the prefix slice stays legal even when PREFIX_W exceeds INSTR_W.
   assign instr_w      = WIDE_W'(Instr);
   assign unused_instr = ^instr_w;

   // Field extraction and extension at the full output width.
   always_comb begin
      field_c = '0;
      case (ImmSrc)
         3'b000, 3'b001: field_c = OUT_W'(instr_w[18:0]);
         3'b010:         field_c = OUT_W'(instr_w[16:0]);
         3'b011:         field_c = OUT_W'(instr_w[15:0]);
         3'b100:         field_c = {{(OUT_W-16){instr_w[15]}}, instr_w[15:0]};
         3'b101:         field_c = {{(OUT_W-17){instr_w[16]}}, instr_w[16:0]};
         default:        field_c = '0;
      endcase
   end

   assign merged_c = {prefix_reg, field_c[LOW_W-1:0]};

   // Next-state and next-output logic; flush beats stall beats accept.
   always_comb begin
      state_nxt     = state;
      prefix_nxt    = prefix_reg;
      ext_nxt       = ExtImm;
      out_valid_nxt = out_valid;
      if (flush) begin
         state_nxt     = IDLE;
         out_valid_nxt = 1'b0;
      end else if (!stall) begin
         out_valid_nxt = 1'b0;
         if (in_valid) begin
            if (ImmSrc == 3'b110) begin
               prefix_nxt = instr_w[PREFIX_W-1:0];
               state_nxt  = PREFIX;
            end else begin
               ext_nxt       = (state == PREFIX) ? merged_c : field_c;
               out_valid_nxt = 1'b1;
               state_nxt     = IDLE;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         prefix_reg     <= '0;
         ExtImm         <= '0;
         out_valid      <= 1'b0;
         prefix_pending <= 1'b0;
      end else begin
         state          <= state_nxt;
         prefix_reg     <= prefix_nxt;
         ExtImm         <= ext_nxt;
         out_valid      <= out_valid_nxt;
         prefix_pending <= (state_nxt == PREFIX);
      end
   end

endmodule

// File: tb/tb_imm_extend_seq.sv
// Bench for imm_extend_seq: two widths driven in lockstep, checked
// against an arithmetic reference model plus directed literal checks.
module tb_imm_extend_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [27:0] instr;
   logic [2:0]  imm_src;
   logic        stall;
   logic        flush;

   logic        ov0, pp0, ov1, pp1;
   logic [31:0] ext0;
   logic [23:0] ext1;

   int n_cmp = 0;
   int n_err = 0;

   int          ow [2] = '{32, 24};
   int          pw [2] = '{16, 8};
   logic        m_ov   [2];
   logic        m_pend [2];
   logic [63:0] m_ext  [2];
   logic [63:0] m_pfx  [2];

   always #5 clk = ~clk;

   imm_extend_seq #(.INSTR_W(28), .OUT_W(32), .PREFIX_W(16)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .Instr(instr), .ImmSrc(imm_src),
      .stall(stall), .flush(flush), .out_valid(ov0), .ExtImm(ext0),
      .prefix_pending(pp0));

   imm_extend_seq #(.INSTR_W(28), .OUT_W(24), .PREFIX_W(8)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .Instr(instr), .ImmSrc(imm_src),
      .stall(stall), .flush(flush), .out_valid(ov1), .ExtImm(ext1),
      .prefix_pending(pp1));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [63:0] mask(input int w);
      return (64'd1 << w) - 64'd1;
   endfunction

   // Field value as a signed/unsigned integer, reduced modulo 2**w.
   function automatic logic [63:0] field(input logic [2:0] src, input logic [27:0] ins, input int w);
      longint v;
      longint raw = longint'(ins);
      case (src)
         3'd0, 3'd1: v = raw % 524288;
         3'd2:       v = raw % 131072;
         3'd3:       v = raw % 65536;
         3'd4: begin v = raw % 65536;  if (v >= 32768) v = v - 65536;  end
         3'd5: begin v = raw % 131072; if (v >= 65536) v = v - 131072; end
         default:    v = 0;
      endcase
      return 64'(v) & mask(w);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_ov[k] = 1'b0; m_pend[k] = 1'b0; m_ext[k] = '0; m_pfx[k] = '0;
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         if (flush) begin
            m_ov[k] = 1'b0; m_pend[k] = 1'b0;
         end else if (!stall) begin
            m_ov[k] = 1'b0;
            if (in_valid) begin
               if (imm_src == 3'd6) begin
                  m_pfx[k]  = 64'(instr) % (64'd1 << pw[k]);
                  m_pend[k] = 1'b1;
               end else begin
                  logic [63:0] f = field(imm_src, instr, ow[k]);
                  int lw = ow[k] - pw[k];
                  if (m_pend[k])
                     m_ext[k] = (m_pfx[k] * (64'd1 << lw) + f % (64'd1 << lw)) & mask(ow[k]);
                  else
                     m_ext[k] = f;
                  m_ov[k] = 1'b1; m_pend[k] = 1'b0;
               end
            end
         end
      end
   endtask

   task automatic check_model();
      check("ov0",  64'(ov0),  64'(m_ov[0]));
      check("ext0", 64'(ext0), m_ext[0]);
      check("pp0",  64'(pp0),  64'(m_pend[0]));
      check("ov1",  64'(ov1),  64'(m_ov[1]));
      check("ext1", 64'(ext1), m_ext[1]);
      check("pp1",  64'(pp1),  64'(m_pend[1]));
   endtask

   // Drive one cycle, advance the model at the edge, sample 1 time unit later.
   task automatic cyc(input logic iv, input logic [27:0] ins, input logic [2:0] src,
                      input logic st, input logic fl);
      in_valid = iv; instr = ins; imm_src = src; stall = st; flush = fl;
      @(posedge clk);
      model_step();
      #1;
      check_model();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; instr = '0; imm_src = '0; stall = 1'b0; flush = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_model();
      rst = 1'b0;

      cyc(1, 28'hABCD, 3'd3, 0, 0);
      check("abcd", 64'(ext0), 64'h0000ABCD);
      check("abcd_v", 64'(ov0), 64'd1);
      cyc(0, 28'h0, 3'd0, 0, 0);
      check("idle_v", 64'(ov0), 64'd0);
      cyc(1, 28'h8001, 3'd4, 0, 0);
      check("sx16", 64'(ext0), 64'hFFFF8001);
      check("sx16_24", 64'(ext1), 64'hFF8001);
      cyc(1, 28'h0FFFF, 3'd5, 0, 0);
      check("sx17", 64'(ext0), 64'h0000FFFF);

      cyc(1, 28'h1234, 3'd6, 0, 0);
      check("pfx_v", 64'(ov0), 64'd0);
      check("pfx_pp", 64'(pp0), 64'd1);
      cyc(1, 28'h5678, 3'd3, 0, 0);
      check("merge", 64'(ext0), 64'h12345678);
      check("merge_pp", 64'(pp0), 64'd0);

      cyc(1, 28'h1234, 3'd6, 0, 0);
      cyc(1, 28'hBEEF, 3'd6, 0, 0);
      cyc(1, 28'h5678, 3'd3, 0, 0);
      check("repfx", 64'(ext0), 64'hBEEF5678);

      cyc(1, 28'h1234, 3'd6, 0, 0);
      repeat (3) cyc(1, 28'h5678, 3'd3, 1, 0);
      check("stall_pp", 64'(pp0), 64'd1);
      check("stall_v", 64'(ov0), 64'd0);
      cyc(1, 28'h7FFFF, 3'd0, 0, 0);
      check("stall_merge", 64'(ext0), 64'h1234FFFF);

      cyc(1, 28'h1234, 3'd6, 0, 0);
      cyc(1, 28'h9999, 3'd3, 1, 1);
      check("flush_pp", 64'(pp0), 64'd0);
      check("flush_v", 64'(ov0), 64'd0);
      cyc(1, 28'h0042, 3'd3, 0, 0);
      check("post_flush", 64'(ext0), 64'h00000042);

      cyc(1, 28'hA5, 3'd6, 0, 0);
      cyc(1, 28'h1234, 3'd3, 0, 0);
      check("merge24", 64'(ext1), 64'hA51234);
      check("merge32_a5", 64'(ext0), 64'h00A51234);

      // Asynchronous reset while a prefix is held.
      cyc(1, 28'h1234, 3'd6, 0, 0);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      model_reset();
      check("arst_pp", 64'(pp0), 64'd0);
      check("arst_ext", 64'(ext0), 64'd0);
      check("arst_v", 64'(ov0), 64'd0);
      check_model();
      #1 rst = 1'b0;
      cyc(1, 28'hFFFFFFF, 3'd7, 0, 0);
      check("rsvd", 64'(ext0), 64'd0);
      check("rsvd_v", 64'(ov0), 64'd1);

      for (int i = 0; i < 400; i++) begin
         logic [2:0] src = ($urandom_range(0, 3) == 0) ? 3'd6 : 3'($urandom_range(0, 7));
         cyc(($urandom_range(0, 3) != 0), 28'($urandom), src,
             ($urandom_range(0, 6) == 0), ($urandom_range(0, 19) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/imm_extend_seq.md
Name: imm_extend_seq

Overview:
- Parametrised, registered successor to the combinational immediate extender in the decode stage.
- Produces an OUT_W-bit immediate with zero- or sign-extension modes.
- Supports a two-instruction "prefix" sequence: a prefix instruction latches the upper immediate bits, and the next immediate-consuming instruction merges them in.
- Sits between the decode latch and the execute stage, with one registered stage, stall and flush.

Parameters:
- INSTR_W, 28, instruction field width fed from decode.
- OUT_W, 32, extended immediate width; legal range 19 to 64.
- PREFIX_W, 16, prefix bits latched from Instr[PREFIX_W-1:0]; legal range 1 to OUT_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  Instr/ImmSrc valid this cycle.
- Instr  input  INSTR_W  instruction bits.
- ImmSrc  input  3  extension mode.
- stall  input  1  hold the output register and state.
- flush  input  1  discard the pending prefix and the output.
- out_valid  output  1  ExtImm valid.
- ExtImm  output  OUT_W  extended immediate.
- prefix_pending  output  1  a prefix is held and awaits its consumer.

Behaviour:
- Reset (async, rst=1): out_valid=0, ExtImm=0, prefix_pending=0, state=IDLE, prefix register=0.
- ImmSrc modes; field value F, zero/sign-extended to OUT_W:
  - 000: Instr[18:0], zero-extended.
  - 001: Instr[18:0], zero-extended.
  - 010: Instr[16:0], zero-extended.
  - 011: Instr[15:0], zero-extended.
  - 100: Instr[15:0], sign-extended (bit 15).
  - 101: Instr[16:0], sign-extended (bit 16).
  - 110: PREFIX.
  - 111: reserved, F=0.
- Latency: one cycle. An accepted input at edge N appears on ExtImm/out_valid after edge N.
- Accept condition: in_valid=1, stall=0, flush=0.
- State machine, two states:
  - IDLE:
    - Accepted mode 110: prefix_reg <= Instr[PREFIX_W-1:0]; go to PREFIX; out_valid <= 0.
    - Any other accepted mode: ExtImm <= F; out_valid <= 1.
  - PREFIX:
    - Accepted mode 000-111: ExtImm <= {prefix_reg, F[OUT_W-PREFIX_W-1:0]}; out_valid <= 1; go to IDLE. A reserved mode still consumes the prefix and gives {prefix_reg, 0}.
    - Accepted mode 110 (second prefix): prefix_reg is replaced with the new value; stay in PREFIX; out_valid <= 0.
- No accepted input and stall=0: out_valid <= 0, ExtImm holds its last value, state unchanged.
- stall=1 and flush=0: all registers hold, including out_valid and ExtImm; inputs are ignored. Upstream must hold Instr.
- Flush: flush=1 has priority over stall and in_valid.
  - Next edge: out_valid <= 0, state <= IDLE, prefix_pending <= 0.
  - ExtImm holds; prefix_reg is don't-care.
- prefix_pending = (state==PREFIX), registered.
- Reset asserted mid-sequence (prefix held) returns everything to reset values immediately, without waiting for a clock edge.
- Width rules:
  - Extension is performed at OUT_W before the merge.
  - Bits above OUT_W-PREFIX_W of F are dropped when merging.
  - Instr bits above 18 are ignored, except in mode 110 when PREFIX_W > 19.

Test Plan:
- Reset, then mode 011 with Instr[15:0]=16'hABCD -> one cycle later ExtImm=32'h0000ABCD, out_valid=1, then out_valid=0 after the next idle edge.
- Mode 100 with Instr[15:0]=16'h8001 -> ExtImm=32'hFFFF8001; mode 101 with Instr[16:0]=17'h0FFFF -> 32'h0000FFFF.
- Mode 110 with Instr[15:0]=16'h1234 (expect out_valid=0, prefix_pending=1), then mode 011 with 16'h5678 -> ExtImm=32'h12345678, prefix_pending=0.
  - Repeat with a second prefix 16'hBEEF inserted before the consumer -> 32'hBEEF5678.
- Prefix 16'h1234, then 3 cycles of stall=1 with in_valid=1 -> state and outputs frozen.
  - Release and consume with mode 000 and Instr[18:0]=19'h7FFFF -> ExtImm=32'h1234FFFF.
- Prefix held, then flush=1 together with stall=1 -> prefix_pending=0, out_valid=0.
  - Following mode 011 with 16'h0042 -> ExtImm=32'h00000042 (no merge).
- Prefix held, async rst pulse between clock edges -> outputs 0 immediately.
  - Following mode 111 -> ExtImm=0, out_valid=1.
  - Re-run the merge case with OUT_W=24, PREFIX_W=8 (prefix 8'hA5 with mode 011 16'h1234 -> 24'hA51234).
